// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared state encoding and parameter defaults for serial_bit_tx
package serial_tx_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MSB_FIRST = 1;
  localparam int DEF_GAP       = 1;

  // ST_ prefix keeps the GAP state distinct from the GAP module parameter.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_t;

endpackage

// File: rtl/piso_shreg.sv
// rtl/piso_shreg.sv - parallel-in serial-out register; sout is the bit currently on the line
module piso_shreg
  import serial_tx_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MSB_FIRST = DEF_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
    end else if (clear) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      if (MSB_FIRST != 0) sreg <= {sreg[WIDTH-2:0], 1'b0};
      else                sreg <= {1'b0, sreg[WIDTH-1:1]};
    end
  end

  // The head bit is a flop output, so the serial line stays registered.
  assign sout = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];

endmodule

// File: rtl/serial_bit_tx.sv
// rtl/serial_bit_tx.sv - word serializer with repeat count, inter-copy gap and done pulse
module serial_bit_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MSB_FIRST = DEF_MSB_FIRST,
  parameter int GAP       = DEF_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [3:0]       rep,
  output logic             ready,
  output logic             a,
  output logic             a_valid,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PENULT_BIT = CNT_W'(WIDTH - 2);
  localparam logic [3:0]       GAP_LAST   = 4'((GAP > 0) ? GAP - 1 : 0);

  tx_state_t        state, state_n;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [3:0]       copy_cnt, copy_cnt_n;
  logic [3:0]       gap_cnt, gap_cnt_n;
  logic [WIDTH-1:0] word, word_n;
  logic             ready_n, valid_n, done_n;
  logic             sh_clear, sh_load, sh_shift;
  logic [WIDTH-1:0] sh_din;

  // Fresh words come straight from din; repeat copies come from the captured word.
  assign sh_din = (state == ST_IDLE) ? din : word;

  piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .clear (sh_clear),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (sh_din),
    .sout  (a)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      copy_cnt <= '0;
      gap_cnt  <= '0;
      word     <= '0;
      ready    <= 1'b1;
      a_valid  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      copy_cnt <= copy_cnt_n;
      gap_cnt  <= gap_cnt_n;
      word     <= word_n;
      ready    <= ready_n;
      a_valid  <= valid_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    copy_cnt_n = copy_cnt;
    gap_cnt_n  = gap_cnt;
    word_n     = word;
    done_n     = 1'b0;
    sh_clear   = 1'b0;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (load && ready) begin
          state_n    = ST_SHIFT;
          word_n     = din;
          copy_cnt_n = rep;
          bit_cnt_n  = '0;
          sh_load    = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          bit_cnt_n = '0;
          if (copy_cnt != 4'd0) begin
            copy_cnt_n = copy_cnt - 4'd1;
            if (GAP > 0) begin
              state_n   = ST_GAP;
              gap_cnt_n = GAP_LAST;
              sh_clear  = 1'b1;
            end else begin
              sh_load = 1'b1;
            end
          end else begin
            state_n  = ST_IDLE;
            sh_clear = 1'b1;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
          sh_shift  = 1'b1;
          // done is registered, so it is raised on the edge entering the last bit.
          if (bit_cnt == PENULT_BIT && copy_cnt == 4'd0) done_n = 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_cnt == 4'd0) begin
          state_n   = ST_SHIFT;
          bit_cnt_n = '0;
          sh_load   = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt - 4'd1;
        end
      end

      default: begin
        state_n  = ST_IDLE;
        sh_clear = 1'b1;
      end
    endcase

    ready_n = (state_n == ST_IDLE);
    valid_n = (state_n == ST_SHIFT);
  end

endmodule

// File: tb/tb_serial_bit_tx.sv
// tb/tb_serial_bit_tx.sv - directed self-checking bench for serial_bit_tx
module tb_serial_bit_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'h00;
  logic [3:0] rep = 4'd0;
  logic       load0 = 1'b0, load1 = 1'b0, load2 = 1'b0;
  logic       ready0, a0, v0, done0;
  logic       ready1, a1, v1, done1;
  logic       ready2, a2, v2, done2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  serial_bit_tx #(.WIDTH(8), .MSB_FIRST(1), .GAP(1)) dut0 (
    .clk(clk), .rst(rst), .load(load0), .din(din), .rep(rep),
    .ready(ready0), .a(a0), .a_valid(v0), .done(done0));

  serial_bit_tx #(.WIDTH(8), .MSB_FIRST(0), .GAP(1)) dut1 (
    .clk(clk), .rst(rst), .load(load1), .din(din), .rep(rep),
    .ready(ready1), .a(a1), .a_valid(v1), .done(done1));

  serial_bit_tx #(.WIDTH(8), .MSB_FIRST(1), .GAP(0)) dut2 (
    .clk(clk), .rst(rst), .load(load2), .din(din), .rep(rep),
    .ready(ready2), .a(a2), .a_valid(v2), .done(done2));

  task automatic accept_load(input int which, input logic [7:0] d, input logic [3:0] r);
    @(posedge clk);
    #1;
    din = d;
    rep = r;
    if (which == 0) load0 = 1'b1;
    else if (which == 1) load1 = 1'b1;
    else load2 = 1'b1;
    @(posedge clk);
    #1;
    load0 = 1'b0;
    load1 = 1'b0;
    load2 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #2;
    checks++;
    if ({ready0, a0, v0, done0} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_dut0 got rdy/a/v/done=%b exp 1000", {ready0, a0, v0, done0});
    end
    checks++;
    if ({ready1, a1, v1, done1} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_dut1 got rdy/a/v/done=%b exp 1000", {ready1, a1, v1, done1});
    end
    checks++;
    if ({ready2, a2, v2, done2} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_dut2 got rdy/a/v/done=%b exp 1000", {ready2, a2, v2, done2});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_msb_first;
    logic [7:0] seq;
    logic       exp_d;
    seq = 8'b1011_0010;
    accept_load(0, 8'hB2, 4'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_d = (i == 7);
      checks++;
      if (a0 !== seq[7-i] || v0 !== 1'b1 || done0 !== exp_d || ready0 !== 1'b0) begin
        errors++;
        $display("FAIL msb_bit%0d got a=%b v=%b done=%b rdy=%b exp a=%b v=1 done=%b rdy=0",
                 i, a0, v0, done0, ready0, seq[7-i], exp_d);
      end
    end
    @(negedge clk);
    checks++;
    if ({ready0, a0, v0, done0} !== 4'b1000) begin
      errors++;
      $display("FAIL msb_idle got rdy/a/v/done=%b exp 1000", {ready0, a0, v0, done0});
    end
  endtask

  task automatic test_lsb_first;
    logic [7:0] seq;
    logic       exp_d;
    seq = 8'b0100_1101;
    accept_load(1, 8'hB2, 4'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_d = (i == 7);
      checks++;
      if (a1 !== seq[7-i] || v1 !== 1'b1 || done1 !== exp_d) begin
        errors++;
        $display("FAIL lsb_bit%0d got a=%b v=%b done=%b exp a=%b v=1 done=%b",
                 i, a1, v1, done1, seq[7-i], exp_d);
      end
    end
    @(negedge clk);
    checks++;
    if ({ready1, v1} !== 2'b10) begin
      errors++;
      $display("FAIL lsb_idle got rdy/v=%b exp 10", {ready1, v1});
    end
  endtask

  task automatic test_repeat_gap;
    int   f;
    int   done_count;
    logic exp_a, exp_v, exp_d;
    done_count = 0;
    accept_load(0, 8'hF0, 4'd2);
    din = 8'h0F;
    rep = 4'd15;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      f = c % 9;
      exp_v = (f != 8);
      exp_a = (f < 4);
      exp_d = (c == 25);
      if (done0 === 1'b1) done_count++;
      checks++;
      if (a0 !== exp_a || v0 !== exp_v || done0 !== exp_d || ready0 !== 1'b0) begin
        errors++;
        $display("FAIL repeat_cyc%0d got a=%b v=%b done=%b rdy=%b exp a=%b v=%b done=%b rdy=0",
                 c, a0, v0, done0, ready0, exp_a, exp_v, exp_d);
      end
    end
    @(negedge clk);
    checks++;
    if ({ready0, v0} !== 2'b10) begin
      errors++;
      $display("FAIL repeat_idle got rdy/v=%b exp 10", {ready0, v0});
    end
    checks++;
    if (done_count != 1) begin
      errors++;
      $display("FAIL repeat_done_count got %0d exp 1", done_count);
    end
  endtask

  task automatic test_no_gap;
    logic [7:0] seq;
    logic       exp_d;
    seq = 8'b1010_0101;
    accept_load(2, 8'hA5, 4'd1);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      exp_d = (c == 15);
      checks++;
      if (a2 !== seq[7-(c%8)] || v2 !== 1'b1 || done2 !== exp_d) begin
        errors++;
        $display("FAIL nogap_cyc%0d got a=%b v=%b done=%b exp a=%b v=1 done=%b",
                 c, a2, v2, done2, seq[7-(c%8)], exp_d);
      end
    end
    @(negedge clk);
    checks++;
    if ({ready2, v2} !== 2'b10) begin
      errors++;
      $display("FAIL nogap_idle got rdy/v=%b exp 10", {ready2, v2});
    end
  endtask

  task automatic test_drop_busy_load;
    logic exp_d;
    accept_load(0, 8'hFF, 4'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_d = (i == 7);
      checks++;
      if (a0 !== 1'b1 || v0 !== 1'b1 || done0 !== exp_d) begin
        errors++;
        $display("FAIL drop_bit%0d got a=%b v=%b done=%b exp a=1 v=1 done=%b",
                 i, a0, v0, done0, exp_d);
      end
      if (i == 2) begin
        load0 = 1'b1;
        din   = 8'h00;
      end
      if (i == 3) load0 = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({ready0, v0} !== 2'b10) begin
        errors++;
        $display("FAIL drop_after%0d got rdy/v=%b exp 10", i, {ready0, v0});
      end
    end
  endtask

  task automatic test_reset_mid_word;
    logic [7:0] seq;
    logic       exp_d;
    seq = 8'b1011_0010;
    accept_load(0, 8'hB2, 4'd0);
    for (int i = 0; i < 4; i++) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ready0, a0, v0, done0} !== 4'b1000) begin
      errors++;
      $display("FAIL rstmid_async got rdy/a/v/done=%b exp 1000", {ready0, a0, v0, done0});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({ready0, v0, done0} !== 3'b100) begin
      errors++;
      $display("FAIL rstmid_held got rdy/v/done=%b exp 100", {ready0, v0, done0});
    end
    rst   = 1'b0;
    din   = 8'hB2;
    rep   = 4'd0;
    load0 = 1'b1;
    @(posedge clk);
    #1;
    load0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_d = (i == 7);
      checks++;
      if (a0 !== seq[7-i] || v0 !== 1'b1 || done0 !== exp_d) begin
        errors++;
        $display("FAIL rstmid_bit%0d got a=%b v=%b done=%b exp a=%b v=1 done=%b",
                 i, a0, v0, done0, seq[7-i], exp_d);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [7:0] seq;
    logic       exp_a, exp_v, exp_d, exp_r;
    int         k;
    seq = 8'b1011_0010;
    @(posedge clk);
    #1;
    din   = 8'hB2;
    rep   = 4'd0;
    load0 = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      k = c % 9;
      if (c >= 17) begin
        exp_v = 1'b0; exp_a = 1'b0; exp_d = 1'b0; exp_r = 1'b1;
      end else if (k == 8) begin
        exp_v = 1'b0; exp_a = 1'b0; exp_d = 1'b0; exp_r = 1'b1;
      end else begin
        exp_v = 1'b1; exp_a = seq[7-k]; exp_d = (k == 7); exp_r = 1'b0;
      end
      checks++;
      if (a0 !== exp_a || v0 !== exp_v || done0 !== exp_d || ready0 !== exp_r) begin
        errors++;
        $display("FAIL b2b_cyc%0d got a=%b v=%b done=%b rdy=%b exp a=%b v=%b done=%b rdy=%b",
                 c, a0, v0, done0, ready0, exp_a, exp_v, exp_d, exp_r);
      end
      if (c == 16) load0 = 1'b0;
    end
  endtask

  initial begin
    test_reset;
    test_msb_first;
    test_lsb_first;
    test_repeat_gap;
    test_no_gap;
    test_drop_busy_load;
    test_reset_mid_word;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
